// File: rtl/coin_pkg.sv
// Shared types and constants for the coin acceptor front end.
package coin_pkg;

  localparam int COIN_W      = 8;
  localparam int NUM_LANES   = 3;
  localparam int HOLDOFF_CYC = 2;

  typedef enum logic [1:0] {
    IDLE,
    PULSE,
    HOLD,
    GAP
  } emit_state_t;

endpackage

// File: rtl/coin_debounce.sv
// Per-lane debouncer: one-cycle qual_event when the lane qualifies high;
// re-arms only after DEB_CYC consecutive low cycles.
module coin_debounce #(
  parameter int DEB_CYC = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic sense,
  output logic qual_event
);

  localparam int CW = (DEB_CYC > 1) ? $clog2(DEB_CYC) : 1;
  localparam logic [CW-1:0] LAST = CW'(DEB_CYC - 1);

  logic          qual;
  logic [CW-1:0] cnt;

  // cnt tracks consecutive cycles where sense disagrees with the qualified level
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      qual       <= 1'b0;
      cnt        <= '0;
      qual_event <= 1'b0;
    end else begin
      qual_event <= 1'b0;
      if (sense != qual) begin
        if (cnt == LAST) begin
          qual       <= sense;
          cnt        <= '0;
          qual_event <= sense;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end else begin
        cnt <= '0;
      end
    end
  end

endmodule

// File: rtl/coin_acceptor_tx.sv
// Coin acceptor to dispenser link: debounce, coin FIFO, strobe emitter, dispense holdoff.
// Optional macro COIN_REJECT_EN adds the coin_reject pulse output.
module coin_acceptor_tx
  import coin_pkg::*;
#(
  parameter logic [COIN_W-1:0] VAL0 = 8'd5,
  parameter logic [COIN_W-1:0] VAL1 = 8'd10,
  parameter logic [COIN_W-1:0] VAL2 = 8'd25,
  parameter int DEB_CYC    = 4,
  parameter int FIFO_DEPTH = 4,
  parameter int GAP_CYC    = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NUM_LANES-1:0] coin_sense,
  input  logic                 disp_d,
  output logic                 coin_c,
  output logic [COIN_W-1:0]    coin_a,
  output logic                 coin_pending
`ifdef COIN_REJECT_EN
  ,
  output logic                 coin_reject
`endif
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int GW = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;
  localparam int HW = $clog2(HOLDOFF_CYC + 1);

  logic [NUM_LANES-1:0] lane_event;
  logic [COIN_W-1:0]    lane_val [NUM_LANES];
  logic [COIN_W-1:0]    push_val;
  logic [COIN_W-1:0]    fifo_mem [FIFO_DEPTH];
  logic [COIN_W-1:0]    head;
  logic [AW-1:0]        wr_ptr, rd_ptr;
  logic [AW:0]          count, count_next;
  logic [HW-1:0]        holdoff;
  logic [GW-1:0]        gap_cnt;
  emit_state_t          state;
  logic                 single, full, push, launch, busy_next;

  assign lane_val[0] = VAL0;
  assign lane_val[1] = VAL1;
  assign lane_val[2] = VAL2;

  for (genvar gi = 0; gi < NUM_LANES; gi++) begin : g_lane
    coin_debounce #(.DEB_CYC(DEB_CYC)) u_deb (
      .clk        (clk),
      .reset      (reset),
      .sense      (coin_sense[gi]),
      .qual_event (lane_event[gi])
    );
  end

  // Full is judged on the current count, so a same-cycle pop never makes room
  assign single = $onehot(lane_event);
  assign full   = (count == (AW + 1)'(FIFO_DEPTH));
  assign push   = single && !full;
  assign head   = fifo_mem[rd_ptr];

  always_comb begin
    push_val = '0;
    for (int i = 0; i < NUM_LANES; i++)
      if (lane_event[i]) push_val = lane_val[i];
  end

  // The last GAP cycle may launch directly so strobes are 2+GAP_CYC apart
  assign launch = (count != '0) && (holdoff == '0) && !disp_d &&
                  ((state == IDLE) || ((state == GAP) && (gap_cnt == '0)));

  always_comb begin
    count_next = count;
    if (push && !launch) count_next = count + 1'b1;
    if (launch && !push) count_next = count - 1'b1;
  end

  always_comb begin
    case (state)
      IDLE:    busy_next = launch;
      GAP:     busy_next = launch || (gap_cnt != '0);
      default: busy_next = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr] <= push_val;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      count        <= '0;
      holdoff      <= '0;
      coin_pending <= 1'b0;
    end else begin
      if (push)   wr_ptr <= wr_ptr + 1'b1;
      if (launch) rd_ptr <= rd_ptr + 1'b1;
      count        <= count_next;
      coin_pending <= (count_next != '0) || busy_next;
      if (disp_d)             holdoff <= HW'(HOLDOFF_CYC);
      else if (holdoff != '0) holdoff <= holdoff - 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      coin_c  <= 1'b0;
      coin_a  <= '0;
      gap_cnt <= '0;
    end else begin
      case (state)
        IDLE, GAP: begin
          if (launch) begin
            state  <= PULSE;
            coin_c <= 1'b1;
            coin_a <= head;
          end else if (state == GAP) begin
            if (gap_cnt == '0) state <= IDLE;
            else               gap_cnt <= gap_cnt - 1'b1;
          end
        end
        PULSE: begin
          state  <= HOLD;
          coin_c <= 1'b0;
        end
        HOLD: begin
          state   <= GAP;
          coin_a  <= '0;
          gap_cnt <= GW'(GAP_CYC - 1);
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef COIN_REJECT_EN
  // Ambiguous multi-lane cycles and pushes into a full queue are both rejects
  always_ff @(posedge clk or posedge reset) begin
    if (reset) coin_reject <= 1'b0;
    else       coin_reject <= ((lane_event != '0) && !single) || (single && full);
  end
`endif

endmodule

// File: tb/tb_coin_acceptor_tx.sv
// Directed bench for coin_acceptor_tx; reject checks are active when COIN_REJECT_EN is defined.
module tb_coin_acceptor_tx;

  logic       clk = 1'b0;
  logic       reset;
  logic [2:0] coin_sense;
  logic       disp_d;
  logic       coin_c;
  logic [7:0] coin_a;
  logic       coin_pending;
`ifdef COIN_REJECT_EN
  logic       coin_reject;
`endif

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int rej_cnt = 0;
  int s_cyc[$];
  int s_val[$];
  int k, d, rej0;

  coin_acceptor_tx dut (
    .clk          (clk),
    .reset        (reset),
    .coin_sense   (coin_sense),
    .disp_d       (disp_d),
    .coin_c       (coin_c),
    .coin_a       (coin_a),
    .coin_pending (coin_pending)
`ifdef COIN_REJECT_EN
    ,
    .coin_reject  (coin_reject)
`endif
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Strobe log sampled mid-cycle: cycle number and coin value of each strobe
  always @(negedge clk) begin
    if (reset === 1'b0) begin
      if (coin_c === 1'b1) begin
        s_cyc.push_back(cyc);
        s_val.push_back(int'(coin_a));
      end
`ifdef COIN_REJECT_EN
      if (coin_reject === 1'b1) rej_cnt++;
`endif
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic hold_sense(input logic [2:0] v, input int n);
    coin_sense = v;
    repeat (n) tick();
  endtask

  task automatic clear_log();
    s_cyc.delete();
    s_val.delete();
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  initial begin
    reset      = 1'b1;
    coin_sense = 3'b000;
    disp_d     = 1'b0;
    tick();
    tick();
    check("rst_c", coin_c, 0);
    check("rst_a", coin_a, 0);
    check("rst_pending", coin_pending, 0);
`ifdef COIN_REJECT_EN
    check("rst_reject", coin_reject, 0);
`endif
    reset = 1'b0;
    repeat (3) tick();

    // Single dime: high 6 cycles from k, event k+4, strobe k+6
    clear_log();
    k = cyc;
    hold_sense(3'b010, 5);
    check("dime_no_early_c", coin_c, 0);
    check("dime_pending", coin_pending, 1);
    tick();
    coin_sense = 3'b000;
    check("dime_c", coin_c, 1);
    check("dime_a_pulse", coin_a, 10);
    tick();
    check("dime_c_hold", coin_c, 0);
    check("dime_a_hold", coin_a, 10);
    tick();
    check("dime_a_gap", coin_a, 0);
    hold_sense(3'b000, 10);
    check("dime_count", s_cyc.size(), 1);
    if (s_cyc.size() >= 1) check("dime_cycle", s_cyc[0], k + 6);

    // Glitch: 3 high, 2 low, 4 high -> only the second burst counts
    clear_log();
    k = cyc;
    hold_sense(3'b001, 3);
    hold_sense(3'b000, 2);
    hold_sense(3'b001, 4);
    coin_sense = 3'b000;
    check("glitch_none_yet", s_cyc.size(), 0);
    tick();
    check("glitch_c_early", coin_c, 0);
    tick();
    check("glitch_c", coin_c, 1);
    check("glitch_a", coin_a, 5);
    hold_sense(3'b000, 10);
    check("glitch_count", s_cyc.size(), 1);

    // Burst: quarter/nickel/dime events at k+4,k+5,k+6 -> strobes k+6,k+9,k+12
    clear_log();
    k = cyc;
    coin_sense = 3'b100;
    tick();
    coin_sense = 3'b101;
    tick();
    coin_sense = 3'b111;
    repeat (4) tick();
    coin_sense = 3'b011;
    tick();
    coin_sense = 3'b010;
    tick();
    coin_sense = 3'b000;
    repeat (6) tick();
    check("burst_pending_gap", coin_pending, 1);
    tick();
    check("burst_pending_fall", coin_pending, 0);
    check("burst_count", s_cyc.size(), 3);
    if (s_cyc.size() == 3) begin
      check("burst_v0", s_val[0], 25);
      check("burst_v1", s_val[1], 5);
      check("burst_v2", s_val[2], 10);
      check("burst_t0", s_cyc[0], k + 6);
      check("burst_t1", s_cyc[1], k + 9);
      check("burst_t2", s_cyc[2], k + 12);
    end
    hold_sense(3'b000, 8);

    // Overflow: 5 nickels under continuous dispense, 4 kept
    clear_log();
    rej0 = rej_cnt;
    disp_d = 1'b1;
    repeat (5) begin
      hold_sense(3'b001, 4);
      hold_sense(3'b000, 4);
    end
    check("ovf_no_strobe", s_cyc.size(), 0);
    check("ovf_pending", coin_pending, 1);
`ifdef COIN_REJECT_EN
    check("ovf_reject_cnt", rej_cnt - rej0, 1);
`endif
    disp_d = 1'b0;
    d = cyc;
    hold_sense(3'b000, 20);
    check("ovf_count", s_cyc.size(), 4);
    if (s_cyc.size() == 4) begin
      for (int i = 0; i < 4; i++) begin
        check($sformatf("ovf_v%0d", i), s_val[i], 5);
        check($sformatf("ovf_t%0d", i), s_cyc[i], d + 3 + 3 * i);
      end
    end
    check("ovf_pending_end", coin_pending, 0);

    // Holdoff: disp_d in the decision cycle k+5 delays strobe from k+6 to k+9
    clear_log();
    k = cyc;
    hold_sense(3'b010, 4);
    coin_sense = 3'b000;
    tick();
    disp_d = 1'b1;
    tick();
    disp_d = 1'b0;
    check("hold_c_t1", coin_c, 0);
    tick();
    check("hold_c_t2", coin_c, 0);
    tick();
    check("hold_c_t3", coin_c, 0);
    tick();
    check("hold_c_t4", coin_c, 1);
    check("hold_a_t4", coin_a, 10);
    hold_sense(3'b000, 10);
    check("hold_count", s_cyc.size(), 1);

    // Simultaneous lanes 0 and 2: discarded
    clear_log();
    rej0 = rej_cnt;
    hold_sense(3'b101, 5);
`ifdef COIN_REJECT_EN
    check("sim_reject_pulse", coin_reject, 1);
`endif
    check("sim_pending", coin_pending, 0);
    coin_sense = 3'b000;
    tick();
`ifdef COIN_REJECT_EN
    check("sim_reject_end", coin_reject, 0);
`endif
    hold_sense(3'b000, 10);
    check("sim_no_strobe", s_cyc.size(), 0);
`ifdef COIN_REJECT_EN
    check("sim_reject_cnt", rej_cnt - rej0, 1);
`endif

    // Reset during HOLD with a second coin queued
    clear_log();
    coin_sense = 3'b010;
    tick();
    coin_sense = 3'b110;
    repeat (4) tick();
    coin_sense = 3'b000;
    tick();
    check("rsth_c", coin_c, 1);
    check("rsth_a", coin_a, 10);
    tick();
    check("rsth_hold_a", coin_a, 10);
    check("rsth_hold_pending", coin_pending, 1);
    #2 reset = 1'b1;
    #1;
    check("rsth_async_c", coin_c, 0);
    check("rsth_async_a", coin_a, 0);
    check("rsth_async_pending", coin_pending, 0);
    tick();
    tick();
    reset = 1'b0;
    clear_log();
    hold_sense(3'b000, 10);
    check("rsth_fifo_empty", s_cyc.size(), 0);
    check("rsth_pending_end", coin_pending, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
